// File: rtl/uart_loader_pkg.sv
// Shared constants and FSM state encoding for the UART firmware loader.
package uart_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] CMD_HALT  = 8'h03;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_CMD,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CSUM
  } state_t;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: reloads on kick or while disarmed, pulses expired when it runs out.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 300000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic kick,
  input  logic arm,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt     <= LOAD;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (kick || !arm) begin
        cnt <= LOAD;
      end else if (cnt == CW'(1)) begin
        cnt     <= LOAD;
        expired <= 1'b1;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Parses framed packets from the UART byte stream, writes program words to memory
// and controls the core reset.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 300000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_mem_valid,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_ready,
  output logic        o_cpu_rst,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] addr_ptr_q, addr_ptr_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] words_q, words_d;
  logic [7:0]  sum_q, sum_d;
  logic [23:0] asm_q, asm_d;
  logic        run_req_q, run_req_d;
  logic        mem_valid_d, cpu_rst_d, busy_d, done_d, err_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic [3:0]  mem_wstrb_d;
  logic        expired;

  loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .kick    (i_rx_valid),
    .arm     (state_q != ST_SYNC),
    .expired (expired)
  );

  // State and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_SYNC;
      idx_q       <= 2'd0;
      addr_ptr_q  <= 32'd0;
      len_lo_q    <= 8'd0;
      words_q     <= 16'd0;
      sum_q       <= 8'd0;
      asm_q       <= 24'd0;
      run_req_q   <= 1'b0;
      o_mem_valid <= 1'b0;
      o_mem_addr  <= 32'd0;
      o_mem_wdata <= 32'd0;
      o_mem_wstrb <= 4'h0;
      o_cpu_rst   <= 1'b1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_ptr_q  <= addr_ptr_d;
      len_lo_q    <= len_lo_d;
      words_q     <= words_d;
      sum_q       <= sum_d;
      asm_q       <= asm_d;
      run_req_q   <= run_req_d;
      o_mem_valid <= mem_valid_d;
      o_mem_addr  <= mem_addr_d;
      o_mem_wdata <= mem_wdata_d;
      o_mem_wstrb <= mem_wstrb_d;
      o_cpu_rst   <= cpu_rst_d;
      o_busy      <= busy_d;
      o_done      <= done_d;
      o_err       <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_ptr_d  = addr_ptr_q;
    len_lo_d    = len_lo_q;
    words_d     = words_q;
    sum_d       = sum_q;
    asm_d       = asm_q;
    run_req_d   = run_req_q;
    mem_valid_d = o_mem_valid;
    mem_addr_d  = o_mem_addr;
    mem_wdata_d = o_mem_wdata;
    cpu_rst_d   = o_cpu_rst;
    done_d      = 1'b0;
    err_d       = o_err;

    if (o_mem_valid && i_mem_ready) begin
      mem_valid_d = 1'b0;
    end

    if (run_req_q && !o_mem_valid) begin
      cpu_rst_d = 1'b0;
      run_req_d = 1'b0;
    end

    if (i_rx_valid) begin
      case (state_q)
        ST_SYNC: begin
          if (i_rx_data == SYNC_BYTE) begin
            state_d = ST_CMD;
            err_d   = 1'b0;
          end
        end
        ST_CMD: begin
          idx_d   = 2'd0;
          sum_d   = 8'd0;
          state_d = ST_SYNC;
          case (i_rx_data)
            CMD_WRITE: state_d = ST_ADDR;
            CMD_RUN:   run_req_d = 1'b1;
            CMD_HALT: begin
              cpu_rst_d = 1'b1;
              run_req_d = 1'b0;
            end
            default:   err_d = 1'b1;
          endcase
        end
        ST_ADDR: begin
          addr_ptr_d = {i_rx_data, addr_ptr_q[31:8]};
          idx_d      = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            addr_ptr_d[1:0] = 2'b00;
            state_d         = ST_LEN;
          end
        end
        ST_LEN: begin
          len_lo_d = i_rx_data;
          idx_d    = idx_q + 2'd1;
          if (idx_q[0]) begin
            idx_d   = 2'd0;
            words_d = {i_rx_data, len_lo_q};
            state_d = ({i_rx_data, len_lo_q} == 16'd0) ? ST_CSUM : ST_DATA;
          end
        end
        ST_DATA: begin
          sum_d = sum_q + i_rx_data;
          asm_d = {i_rx_data, asm_q[23:8]};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // A word arriving while the previous one is still unaccepted is lost
            if (o_mem_valid && !i_mem_ready) begin
              err_d = 1'b1;
            end else begin
              mem_valid_d = 1'b1;
              mem_addr_d  = addr_ptr_q;
              mem_wdata_d = {i_rx_data, asm_q};
              addr_ptr_d  = addr_ptr_q + 32'd4;
            end
            words_d = words_q - 16'd1;
            if (words_q == 16'd1) begin
              state_d = ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (i_rx_data == sum_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_SYNC;
        end
        default: state_d = ST_SYNC;
      endcase
    end else if (expired && state_q != ST_SYNC) begin
      state_d = ST_SYNC;
      err_d   = 1'b1;
    end

    busy_d      = (state_d != ST_SYNC) || mem_valid_d;
    mem_wstrb_d = mem_valid_d ? 4'hF : 4'h0;
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: packet table plus stall, overflow, run, timeout and reset sequences.
module tb_uart_loader;

  localparam int unsigned TMO = 20000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [7:0]  i_rx_data = 8'd0;
  logic        i_rx_valid = 1'b0;
  logic        o_mem_valid;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic        i_mem_ready = 1'b1;
  logic        o_cpu_rst;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  uart_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_mem_valid (o_mem_valid),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_wstrb (o_mem_wstrb),
    .i_mem_ready (i_mem_ready),
    .o_cpu_rst   (o_cpu_rst),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_fail = 0;
  int writes_seen = 0;
  int dones_seen = 0;
  logic [31:0] w_addr [8];
  logic [31:0] w_data [8];

  always @(posedge i_clk) begin
    if (!i_rst && o_mem_valid && i_mem_ready) begin
      w_addr[writes_seen % 8] = o_mem_addr;
      w_data[writes_seen % 8] = o_mem_wdata;
      writes_seen++;
    end
  end

  always @(negedge i_clk) begin
    if (o_done) dones_seen++;
  end

  typedef struct packed {
    logic [143:0] bytes;
    logic [7:0]   n;
    logic [7:0]   exp_writes;
    logic [7:0]   exp_done;
    logic         exp_err;
    logic         exp_cpu_rst;
    logic [31:0]  a0, d0, a1, d1;
  } vec_t;

  vec_t vecs [6];

  localparam logic [143:0] PKT_GOOD = 144'h64_88776655_44332211_0002_00001000_01_A5;
  localparam logic [143:0] PKT_BAD  = 144'h65_88776655_44332211_0002_00001000_01_A5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk); #1;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [143:0] bb, input int first, input int last);
    for (int k = first; k < last; k++) send_byte(bb[k*8 +: 8]);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 32'(o_mem_valid), 32'd0);
    chk({tag, "_addr"},  o_mem_addr, 32'd0);
    chk({tag, "_wdata"}, o_mem_wdata, 32'd0);
    chk({tag, "_wstrb"}, 32'(o_mem_wstrb), 32'd0);
    chk({tag, "_cpurst"}, 32'(o_cpu_rst), 32'd1);
    chk({tag, "_busy"},  32'(o_busy), 32'd0);
    chk({tag, "_done"},  32'(o_done), 32'd0);
    chk({tag, "_err"},   32'(o_err), 32'd0);
  endtask

  initial begin
    int wr0, dn0;
    logic stable;

    vecs[0] = '{PKT_GOOD, 8'd17, 8'd2, 8'd1, 1'b0, 1'b1,
                32'h1000, 32'h44332211, 32'h1004, 32'h88776655};
    vecs[1] = '{PKT_BAD, 8'd17, 8'd2, 8'd0, 1'b1, 1'b1,
                32'h1000, 32'h44332211, 32'h1004, 32'h88776655};
    vecs[2] = '{144'h00_0000_00000000_01_A5, 8'd9, 8'd0, 8'd1, 1'b0, 1'b1,
                32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{144'h07A5, 8'd2, 8'd0, 8'd0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[4] = '{144'h02A5, 8'd2, 8'd0, 8'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[5] = '{144'h03A5, 8'd2, 8'd0, 8'd0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0};

    // Reset state
    do_reset();
    wait_cyc(1);
    check_reset("rst0");

    // Packet table, memory always ready
    i_mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr0 = writes_seen;
      dn0 = dones_seen;
      send_seq(vecs[i].bytes, 0, int'(vecs[i].n));
      wait_cyc(5);
      chk($sformatf("v%0d_writes", i), 32'(writes_seen - wr0), 32'(vecs[i].exp_writes));
      chk($sformatf("v%0d_done", i), 32'(dones_seen - dn0), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_err", i), 32'(o_err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_cpurst", i), 32'(o_cpu_rst), 32'(vecs[i].exp_cpu_rst));
      chk($sformatf("v%0d_busy", i), 32'(o_busy), 32'd0);
      if (vecs[i].exp_writes > 0) begin
        chk($sformatf("v%0d_a0", i), w_addr[wr0 % 8], vecs[i].a0);
        chk($sformatf("v%0d_d0", i), w_data[wr0 % 8], vecs[i].d0);
      end
      if (vecs[i].exp_writes > 1) begin
        chk($sformatf("v%0d_a1", i), w_addr[(wr0 + 1) % 8], vecs[i].a1);
        chk($sformatf("v%0d_d1", i), w_data[(wr0 + 1) % 8], vecs[i].d1);
      end
    end

    // Long ready stall on the first word
    do_reset();
    i_mem_ready = 1'b0;
    wr0 = writes_seen;
    dn0 = dones_seen;
    send_seq(PKT_GOOD, 0, 12);
    stable = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge i_clk);
      if (o_mem_valid !== 1'b1 || o_mem_addr !== 32'h1000 ||
          o_mem_wdata !== 32'h44332211 || o_mem_wstrb !== 4'hF) stable = 1'b0;
    end
    chk("stall_stable", 32'(stable), 32'd1);
    chk("stall_no_write", 32'(writes_seen - wr0), 32'd0);
    i_mem_ready = 1'b1;
    send_seq(PKT_GOOD, 12, 17);
    wait_cyc(5);
    chk("stall_writes", 32'(writes_seen - wr0), 32'd2);
    chk("stall_a1", w_addr[(wr0 + 1) % 8], 32'h1004);
    chk("stall_d1", w_data[(wr0 + 1) % 8], 32'h88776655);
    chk("stall_done", 32'(dones_seen - dn0), 32'd1);
    chk("stall_err", 32'(o_err), 32'd0);

    // Overflow: ready low across both words
    do_reset();
    i_mem_ready = 1'b0;
    wr0 = writes_seen;
    send_seq(PKT_GOOD, 0, 17);
    wait_cyc(5);
    chk("ovf_err", 32'(o_err), 32'd1);
    chk("ovf_addr", o_mem_addr, 32'h1000);
    chk("ovf_wdata", o_mem_wdata, 32'h44332211);
    i_mem_ready = 1'b1;
    wait_cyc(5);
    chk("ovf_writes", 32'(writes_seen - wr0), 32'd1);

    // RUN waits for the pending write, HALT re-asserts reset
    do_reset();
    i_mem_ready = 1'b0;
    send_seq(144'hAA_44332211_0001_00001000_01_A5, 0, 13);
    send_seq(144'h02A5, 0, 2);
    wait_cyc(20);
    chk("run_held", 32'(o_cpu_rst), 32'd1);
    chk("run_pending", 32'(o_mem_valid), 32'd1);
    i_mem_ready = 1'b1;
    wait_cyc(5);
    chk("run_release", 32'(o_cpu_rst), 32'd0);
    send_seq(144'h03A5, 0, 2);
    wait_cyc(3);
    chk("halt_cpurst", 32'(o_cpu_rst), 32'd1);

    // Inter-byte timeout
    do_reset();
    send_seq(144'h0000_01_A5, 0, 4);
    wait_cyc(TMO - 50);
    chk("tmo_before_err", 32'(o_err), 32'd0);
    chk("tmo_before_busy", 32'(o_busy), 32'd1);
    wait_cyc(100);
    chk("tmo_err", 32'(o_err), 32'd1);
    chk("tmo_busy", 32'(o_busy), 32'd0);
    send_seq(144'h02A5, 0, 2);
    wait_cyc(3);
    chk("tmo_run", 32'(o_cpu_rst), 32'd0);
    chk("tmo_err_clr", 32'(o_err), 32'd0);

    // Asynchronous reset in the middle of DATA with a write pending
    do_reset();
    i_mem_ready = 1'b0;
    send_seq(PKT_GOOD, 0, 13);
    wait_cyc(1);
    chk("mid_pending", 32'(o_mem_valid), 32'd1);
    #1 i_rst = 1'b1;
    #2;
    check_reset("midrst");
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    i_mem_ready = 1'b1;
    wait_cyc(3);
    chk("post_rst_valid", 32'(o_mem_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
